// File: rtl/clock_divider_cfg_ctrl.sv
// Configuration front-end for the clock divider: validates a requested ratio, divides it
// sequentially and applies all four control words together on a divider period boundary.
module clock_divider_cfg_ctrl #(
  parameter int unsigned FACTOR_BIT   = 31,
  parameter int unsigned SYNC_TIMEOUT = 65535
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_cfg_valid,
  output logic                  o_cfg_ready,
  input  logic [FACTOR_BIT-1:0] i_cfg_dividend,
  input  logic [FACTOR_BIT-1:0] i_cfg_divisor,
  input  logic                  i_period_boundary,
  output logic [FACTOR_BIT-1:0] o_clk_dividend,
  output logic [FACTOR_BIT-1:0] o_clk_divisor,
  output logic [FACTOR_BIT-1:0] o_clk_quotient,
  output logic [FACTOR_BIT-1:0] o_clk_remainder,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_sync_timeout,
  output logic                  o_err,
  output logic [1:0]            o_err_code
);

  localparam int unsigned CntW = (FACTOR_BIT > 1) ? $clog2(FACTOR_BIT) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(FACTOR_BIT - 1);
  localparam logic [31:0] TimeoutLast = (SYNC_TIMEOUT == 0) ? 32'd0 : 32'(SYNC_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StCheck, StDiv, StWaitSync} state_e;

  state_e                state_q, state_d;
  logic [FACTOR_BIT-1:0] dvd_q, dvd_d;
  logic [FACTOR_BIT-1:0] dvs_q, dvs_d;
  logic [FACTOR_BIT-1:0] shift_q, shift_d;
  logic [FACTOR_BIT-1:0] rem_q, rem_d;
  logic [FACTOR_BIT-1:0] quo_q, quo_d;
  logic [CntW-1:0]       bit_q, bit_d;
  logic [31:0]           sync_cnt_q, sync_cnt_d;
  logic [FACTOR_BIT-1:0] clk_dividend_q, clk_dividend_d;
  logic [FACTOR_BIT-1:0] clk_divisor_q, clk_divisor_d;
  logic [FACTOR_BIT-1:0] clk_quotient_q, clk_quotient_d;
  logic [FACTOR_BIT-1:0] clk_remainder_q, clk_remainder_d;
  logic                  done_q, done_d;
  logic                  timeout_q, timeout_d;
  logic                  err_q, err_d;
  logic [1:0]            err_code_q, err_code_d;

  // Partial remainder after shifting in the next dividend bit; one bit wider than the operands.
  logic [FACTOR_BIT:0] trial;
  logic [FACTOR_BIT:0] diff;
  logic                ge;

  always_comb begin
    trial = {rem_q, shift_q[FACTOR_BIT-1]};
    diff  = trial - {1'b0, dvs_q};
    ge    = trial >= {1'b0, dvs_q};
  end

  always_comb begin
    state_d         = state_q;
    dvd_d           = dvd_q;
    dvs_d           = dvs_q;
    shift_d         = shift_q;
    rem_d           = rem_q;
    quo_d           = quo_q;
    bit_d           = bit_q;
    sync_cnt_d      = sync_cnt_q;
    clk_dividend_d  = clk_dividend_q;
    clk_divisor_d   = clk_divisor_q;
    clk_quotient_d  = clk_quotient_q;
    clk_remainder_d = clk_remainder_q;
    done_d          = 1'b0;
    timeout_d       = 1'b0;
    err_d           = 1'b0;
    err_code_d      = err_code_q;

    unique case (state_q)
      StIdle: begin
        if (i_cfg_valid) begin
          dvd_d   = i_cfg_dividend;
          dvs_d   = i_cfg_divisor;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (dvs_q == '0) begin
          err_d      = 1'b1;
          err_code_d = 2'd1;
          state_d    = StIdle;
        end else if (dvd_q < dvs_q) begin
          err_d      = 1'b1;
          err_code_d = 2'd2;
          state_d    = StIdle;
        end else begin
          err_code_d = 2'd0;
          rem_d      = '0;
          quo_d      = '0;
          shift_d    = dvd_q;
          bit_d      = '0;
          state_d    = StDiv;
        end
      end
      StDiv: begin
        // A failed trial is below the divisor, so its top bit is always zero.
        rem_d   = ge ? diff[FACTOR_BIT-1:0] : trial[FACTOR_BIT-1:0];
        quo_d   = {quo_q[FACTOR_BIT-2:0], ge};
        shift_d = shift_q << 1;
        bit_d   = bit_q + 1'b1;
        if (bit_q == LastBit) begin
          sync_cnt_d = '0;
          state_d    = StWaitSync;
        end
      end
      StWaitSync: begin
        if (i_period_boundary || (sync_cnt_q >= TimeoutLast)) begin
          clk_dividend_d  = dvd_q;
          clk_divisor_d   = dvs_q;
          clk_quotient_d  = quo_q;
          clk_remainder_d = rem_q;
          done_d          = 1'b1;
          timeout_d       = !i_period_boundary;
          state_d         = StIdle;
        end else begin
          sync_cnt_d = sync_cnt_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q         <= StIdle;
      dvd_q           <= '0;
      dvs_q           <= '0;
      shift_q         <= '0;
      rem_q           <= '0;
      quo_q           <= '0;
      bit_q           <= '0;
      sync_cnt_q      <= '0;
      clk_dividend_q  <= FACTOR_BIT'(1);
      clk_divisor_q   <= FACTOR_BIT'(1);
      clk_quotient_q  <= FACTOR_BIT'(1);
      clk_remainder_q <= '0;
      done_q          <= 1'b0;
      timeout_q       <= 1'b0;
      err_q           <= 1'b0;
      err_code_q      <= 2'd0;
    end else begin
      state_q         <= state_d;
      dvd_q           <= dvd_d;
      dvs_q           <= dvs_d;
      shift_q         <= shift_d;
      rem_q           <= rem_d;
      quo_q           <= quo_d;
      bit_q           <= bit_d;
      sync_cnt_q      <= sync_cnt_d;
      clk_dividend_q  <= clk_dividend_d;
      clk_divisor_q   <= clk_divisor_d;
      clk_quotient_q  <= clk_quotient_d;
      clk_remainder_q <= clk_remainder_d;
      done_q          <= done_d;
      timeout_q       <= timeout_d;
      err_q           <= err_d;
      err_code_q      <= err_code_d;
    end
  end

  assign o_cfg_ready     = (state_q == StIdle);
  assign o_busy          = (state_q != StIdle);
  assign o_clk_dividend  = clk_dividend_q;
  assign o_clk_divisor   = clk_divisor_q;
  assign o_clk_quotient  = clk_quotient_q;
  assign o_clk_remainder = clk_remainder_q;
  assign o_done          = done_q;
  assign o_sync_timeout  = timeout_q;
  assign o_err           = err_q;
  assign o_err_code      = err_code_q;

endmodule

// File: tb/tb_clock_divider_cfg_ctrl.sv
// Scoreboard bench: requests push expected completions; a negedge monitor pops on o_done/o_err
// and keeps a model of the applied control words.
module tb_clock_divider_cfg_ctrl;
  localparam int FB = 8;
  localparam int TO = 24;

  logic          clk = 1'b0;
  logic          rstn;
  logic          valid;
  logic          ready;
  logic [FB-1:0] dividend, divisor;
  logic          boundary;
  logic [FB-1:0] clk_dividend, clk_divisor, clk_quotient, clk_remainder;
  logic          busy, done, sync_to, err;
  logic [1:0]    err_code;

  clock_divider_cfg_ctrl #(.FACTOR_BIT(FB), .SYNC_TIMEOUT(TO)) dut (
    .i_clk             (clk),
    .i_rstn            (rstn),
    .i_cfg_valid       (valid),
    .o_cfg_ready       (ready),
    .i_cfg_dividend    (dividend),
    .i_cfg_divisor     (divisor),
    .i_period_boundary (boundary),
    .o_clk_dividend    (clk_dividend),
    .o_clk_divisor     (clk_divisor),
    .o_clk_quotient    (clk_quotient),
    .o_clk_remainder   (clk_remainder),
    .o_busy            (busy),
    .o_done            (done),
    .o_sync_timeout    (sync_to),
    .o_err             (err),
    .o_err_code        (err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit is_err;
    int code;
    int a, b, q, r;
    bit to;
    int cyc;
  } exp_t;

  exp_t exp_q[$];

  // Model of the words currently applied to the divider.
  int m_a = 1, m_b = 1, m_q = 1, m_r = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rstn === 1'b1) begin
      if (done || err) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got done=%0b err=%0b expected none", done, err);
        end else begin
          e = exp_q.pop_front();
          chk("evt_err", err, e.is_err);
          chk("evt_done", done, !e.is_err);
          chk("evt_cycle", cyc, e.cyc);
          if (e.is_err) begin
            chk("err_code", err_code, e.code);
            chk("timeout_on_err", sync_to, 0);
          end else begin
            chk("err_code_clear", err_code, 0);
            chk("sync_timeout", sync_to, e.to);
            chk("ready_with_done", ready, 1);
            m_a = e.a; m_b = e.b; m_q = e.q; m_r = e.r;
          end
        end
      end else begin
        chk("timeout_without_done", sync_to, 0);
      end
      chk("out_dividend", clk_dividend, m_a);
      chk("out_divisor", clk_divisor, m_b);
      chk("out_quotient", clk_quotient, m_q);
      chk("out_remainder", clk_remainder, m_r);
      chk("ready_vs_busy", ready, !busy);
    end
  end

  // d < 0: boundary held high; otherwise a one-cycle pulse d cycles into WAIT_SYNC.
  task automatic send(input int a, input int b, input int d, input bit intrude);
    exp_t e;
    int   c0;
    int   k;
    int   dd;
    boundary = (d < 0);
    @(negedge clk);
    k = 0;
    while (!ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    valid    = 1'b1;
    dividend = FB'(a);
    divisor  = FB'(b);
    @(posedge clk);
    #1;
    c0    = cyc;
    valid = 1'b0;
    e.a = a; e.b = b; e.q = 0; e.r = 0; e.to = 1'b0; e.code = 0;
    if (b == 0) begin
      e.is_err = 1'b1; e.code = 1; e.cyc = c0 + 1;
    end else if (a < b) begin
      e.is_err = 1'b1; e.code = 2; e.cyc = c0 + 1;
    end else begin
      e.is_err = 1'b0;
      e.q      = a / b;
      e.r      = a % b;
      dd       = (d < 0) ? 0 : d;
      e.to     = (dd >= TO);
      e.cyc    = c0 + FB + 2 + (e.to ? TO - 1 : dd);
    end
    exp_q.push_back(e);
    chk("busy_after_accept", busy, 1);
    chk("ready_after_accept", ready, 0);
    if (!e.is_err) begin
      for (int i = 0; i <= FB; i++) begin
        if (intrude) begin
          valid    = 1'b1;
          dividend = FB'(6);
          divisor  = FB'(3);
          chk("ready_low_while_busy", ready, 0);
        end
        @(posedge clk);
        #1;
      end
      valid = 1'b0;
      if (d >= 0) begin
        repeat (d) @(posedge clk);
        #1 boundary = 1'b1;
        @(posedge clk);
        #1 boundary = 1'b0;
      end
    end
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL completion_wait: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int a, b, d, sel;
    rstn     = 1'b0;
    valid    = 1'b0;
    dividend = '0;
    divisor  = '0;
    boundary = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dividend", clk_dividend, 1);
    chk("rst_divisor", clk_divisor, 1);
    chk("rst_quotient", clk_quotient, 1);
    chk("rst_remainder", clk_remainder, 0);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_timeout", sync_to, 0);
    @(negedge clk);
    rstn = 1'b1;

    send(10, 4, -1, 1'b0);
    send(255, 7, 20, 1'b0);
    send(17, 0, -1, 1'b0);
    send(3, 5, -1, 1'b0);
    send(9, 2, -1 + TO + 10, 1'b0);
    send(10, 4, 5, 1'b1);
    send(255, 1, -1, 1'b0);
    send(200, 200, 0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 0;
      else b = $urandom_range(1, 255);
      if (sel > 2 && b != 0) a = $urandom_range(b, 255);
      else a = $urandom_range(0, 255);
      if ($urandom_range(0, 9) < 3) d = -1;
      else d = $urandom_range(0, TO + 6);
      send(a, b, d, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a division.
    boundary = 1'b0;
    @(negedge clk);
    valid    = 1'b1;
    dividend = FB'(200);
    divisor  = FB'(3);
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    exp_q.delete();
    m_a = 1; m_b = 1; m_q = 1; m_r = 0;
    chk("midrst_dividend", clk_dividend, 1);
    chk("midrst_divisor", clk_divisor, 1);
    chk("midrst_quotient", clk_quotient, 1);
    chk("midrst_remainder", clk_remainder, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", ready, 1);
    @(negedge clk);
    #1 rstn = 1'b1;
    send(8, 8, -1, 1'b0);

    repeat (5) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
